// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline buffers, with
//               stall/flush counters and a data-memory timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int R0_HARDWIRED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_rs,
  input  logic [5:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [5:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        err_timeout,
  output logic        halted
);

  localparam logic [1:0] c_st_run  = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;
  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_next;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        r_err;
  logic        w_rd_valid;
  logic        w_load_use;
  logic        w_mem_pend;
  logic        w_halt_take;
  logic        w_wait;
  logic        w_stall_inc;
  logic        w_flush_inc;

  generate
    if (R0_HARDWIRED != 0) begin : g_r0_hard
      assign w_rd_valid = (ex_rd != 6'd0);
    end else begin : g_r0_soft
      assign w_rd_valid = 1'b1;
    end
  endgenerate

  assign w_load_use = ex_is_load & w_rd_valid &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // Once waiting, only mem_ready ends the wait; a new wait needs mem_req.
  assign w_mem_pend  = (r_state == c_st_wait) ? ~mem_ready
                     : ((r_state == c_st_run) & mem_req & ~mem_ready);
  assign w_halt_take = wb_halt & (r_state != c_st_halt) &
                       ~((r_state == c_st_wait) & ~mem_ready);
  assign w_wait      = w_mem_pend & ~w_halt_take;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if ((r_state == c_st_halt) || w_halt_take) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (w_wait) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      w_stall_inc  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_flush_inc = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
      w_stall_inc = 1'b1;
    end
  end

  always_comb begin
    w_state_next    = c_st_run;
    w_wait_cnt_next = 8'd0;
    if ((r_state == c_st_halt) || w_halt_take) begin
      w_state_next = c_st_halt;
    end else if (w_wait) begin
      w_state_next = c_st_wait;
      if (r_state == c_st_run)
        w_wait_cnt_next = 8'd1;
      else if (r_wait_cnt == c_timeout)
        w_wait_cnt_next = r_wait_cnt;
      else
        w_wait_cnt_next = r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_run;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_stall_inc)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_inc)
        r_flush_cnt <= r_flush_cnt + 32'd1;
      if (w_wait && (w_wait_cnt_next == c_timeout))
        r_err <= 1'b1;
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign err_timeout = r_err;
  assign halted      = (r_state == c_st_halt);

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  // Packed order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble
  localparam logic [6:0] c_o_reset  = 7'b0010101;
  localparam logic [6:0] c_o_normal = 7'b1101010;
  localparam logic [6:0] c_o_memw   = 7'b0000001;
  localparam logic [6:0] c_o_branch = 7'b1111110;
  localparam logic [6:0] c_o_lu     = 7'b0001110;
  localparam logic [6:0] c_o_halt   = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_is_load = 0, ex_branch_taken = 0;
  logic mem_req = 0, mem_ready = 0, wb_halt = 0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic [31:0] stall_cnt, flush_cnt;
  logic err_timeout, halted;
  wire  [6:0] outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_waiting, m_err, m_halted;
  int          m_wait_len;
  logic [31:0] m_stall, m_flush;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .R0_HARDWIRED(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .err_timeout(err_timeout), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_outs();
    bit hazard;
    if (!rst_n) return c_o_reset;
    if (m_halted || (wb_halt && !(m_waiting && !mem_ready))) return c_o_halt;
    if (m_waiting ? !mem_ready : (mem_req && !mem_ready)) return c_o_memw;
    if (ex_branch_taken) return c_o_branch;
    hazard = ex_is_load && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (hazard) return c_o_lu;
    return c_o_normal;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_err = 0; m_halted = 0; m_wait_len = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic model_tick();
    logic [6:0] e;
    e = model_outs();
    if (m_halted) return;
    if (e == c_o_halt) begin
      m_halted = 1; m_waiting = 0; m_wait_len = 0;
    end else if (e == c_o_memw) begin
      m_stall++;
      m_wait_len++;
      m_waiting = 1;
      if (m_wait_len >= MEM_TIMEOUT) m_err = 1;
    end else begin
      m_waiting = 0; m_wait_len = 0;
      if (e == c_o_branch) m_flush++;
      if (e == c_o_lu) m_stall++;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_rd = 0;
    ex_is_load = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0; wb_halt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (outs !== c_o_reset) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs, c_o_reset);
    end
    n_tests++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || err_timeout !== 0 || halted !== 0) begin
      n_fail++; $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b halted=%b want 0",
                         stall_cnt, flush_cnt, err_timeout, halted);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (outs !== c_o_normal) begin
        n_fail++; $display("FAIL idle_outs[%0d]: got %b want %b", i, outs, c_o_normal);
      end
      clk_step();
      n_tests++;
      if (stall_cnt !== 0 || flush_cnt !== 0) begin
        n_fail++; $display("FAIL idle_cnts[%0d]: got stall=%0d flush=%0d want 0", i, stall_cnt, flush_cnt);
      end
    end
  endtask

  task automatic test_load_use();
    ex_is_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_lu) begin
      n_fail++; $display("FAIL load_use_outs: got %b want %b", outs, c_o_lu);
    end
    clk_step();
    n_tests++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_stall: got %0d want 1", stall_cnt);
    end
    ex_rd = 0; id_rs = 0;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_normal) begin
      n_fail++; $display("FAIL load_use_r0_outs: got %b want %b", outs, c_o_normal);
    end
    clk_step();
    n_tests++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_r0_stall: got %0d want 1", stall_cnt);
    end
    // Hazard via the rt operand only
    ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_uses_rs = 0; id_rs = 9;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_lu) begin
      n_fail++; $display("FAIL load_use_rt_outs: got %b want %b", outs, c_o_lu);
    end
    clk_step();
    idle_inputs();
  endtask

  task automatic test_branch();
    logic [31:0] s0;
    s0 = stall_cnt;
    ex_is_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; ex_branch_taken = 1;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_branch) begin
      n_fail++; $display("FAIL branch_outs: got %b want %b", outs, c_o_branch);
    end
    clk_step();
    n_tests++;
    if (flush_cnt !== 32'd1 || stall_cnt !== s0) begin
      n_fail++; $display("FAIL branch_cnts: got flush=%0d stall=%0d want flush=1 stall=%0d",
                         flush_cnt, stall_cnt, s0);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    s0 = stall_cnt;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs !== c_o_memw) begin
        n_fail++; $display("FAIL mem_wait_outs[%0d]: got %b want %b", i, outs, c_o_memw);
      end
      clk_step();
    end
    mem_ready = 1;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_normal) begin
      n_fail++; $display("FAIL mem_ready_outs: got %b want %b", outs, c_o_normal);
    end
    clk_step();
    n_tests++;
    if (stall_cnt - s0 !== 32'd3 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_stall: got delta=%0d err=%b want delta=3 err=0",
                         stall_cnt - s0, err_timeout);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      n_tests++;
      if (err_timeout !== (k >= MEM_TIMEOUT)) begin
        n_fail++; $display("FAIL timeout_err[%0d]: got %b want %b", k, err_timeout, k >= MEM_TIMEOUT);
      end
    end
    mem_ready = 1;
    clk_step();
    idle_inputs();
    clk_step();
    n_tests++;
    if (err_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1; mem_ready = 0;
    clk_step();
    clk_step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (stall_cnt !== 0 || err_timeout !== 0 || outs !== c_o_reset) begin
      n_fail++; $display("FAIL reset_mid_wait: got stall=%0d err=%b outs=%b want 0 0 %b",
                         stall_cnt, err_timeout, outs, c_o_reset);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    #1;
    n_tests++;
    if (outs !== c_o_normal) begin
      n_fail++; $display("FAIL after_reset_outs: got %b want %b", outs, c_o_normal);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_rs = 6'($urandom_range(0, 3)); id_rt = 6'($urandom_range(0, 3));
      ex_rd = 6'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom % 2); id_uses_rt = 1'($urandom % 2);
      ex_is_load = ($urandom % 3) == 0;
      ex_branch_taken = ($urandom % 6) == 0;
      mem_req = m_waiting ? 1'b1 : (($urandom % 3) == 0);
      mem_ready = ($urandom % 4) != 0;
      wb_halt = 0;
      @(negedge clk);
      n_tests++;
      if (outs !== model_outs()) begin
        n_fail++; $display("FAIL rand_outs[%0d]: got %b want %b", i, outs, model_outs());
      end
      clk_step();
      n_tests++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush || err_timeout !== m_err) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got stall=%0d flush=%0d err=%b want %0d %0d %b",
                           i, stall_cnt, flush_cnt, err_timeout, m_stall, m_flush, m_err);
      end
    end
    mem_req = 1; mem_ready = 1;
    clk_step();
    idle_inputs();
  endtask

  task automatic test_halt();
    logic [31:0] s0, f0;
    wb_halt = 1;
    @(negedge clk);
    n_tests++;
    if (outs !== c_o_halt) begin
      n_fail++; $display("FAIL halt_take_outs: got %b want %b", outs, c_o_halt);
    end
    clk_step();
    s0 = stall_cnt; f0 = flush_cnt;
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_flag: got %b want 1", halted);
    end
    wb_halt = 0;
    for (int i = 0; i < 6; i++) begin
      ex_branch_taken = 1'($urandom % 2); ex_is_load = 1; ex_rd = 2; id_rs = 2; id_uses_rs = 1;
      mem_req = 1'($urandom % 2); mem_ready = 0;
      @(negedge clk);
      n_tests++;
      if (outs !== c_o_halt || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got outs=%b halted=%b want %b 1", i, outs, halted, c_o_halt);
      end
      clk_step();
    end
    n_tests++;
    if (stall_cnt !== s0 || flush_cnt !== f0) begin
      n_fail++; $display("FAIL halt_freeze: got stall=%0d flush=%0d want %0d %0d", stall_cnt, flush_cnt, s0, f0);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (halted !== 0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL halt_reset: got halted=%b stall=%0d flush=%0d want 0",
                         halted, stall_cnt, flush_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces per-stage enable and flush/bubble controls for the PC and the four pipeline buffers.
- Resolves load-use hazards, taken-branch flushes, data-memory wait handshakes and halt.
- Keeps stall/flush performance counters and a memory-timeout error flag.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive wait cycles on a data-memory access before err_timeout is raised (range 1..255).
- R0_HARDWIRED, 1, when 1 a destination register of 0 never causes a load-use hazard.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  6  source register A of the instruction in ID.
- id_rt  input  6  source register B of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads id_rs.
- id_uses_rt  input  1  ID instruction reads id_rt.
- ex_rd  input  6  destination register of the instruction in EX (ID/EX rd_out).
- ex_is_load  input  1  instruction in EX is a load.
- ex_branch_taken  input  1  branch in EX resolved taken.
- mem_req  input  1  instruction in MEM accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- wb_halt  input  1  halt instruction is in WB.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID buffer capture enable.
- ifid_flush  output  1  IF/ID captures a NOP.
- idex_en  output  1  ID/EX capture enable.
- idex_flush  output  1  ID/EX captures a bubble (rd=0, no writes).
- exmem_en  output  1  EX/MEM capture enable.
- memwb_bubble  output  1  MEM/WB captures a bubble.
- stall_cnt  output  32  total stall cycles (load-use plus memory wait).
- flush_cnt  output  32  taken-branch flush events.
- err_timeout  output  1  sticky; memory wait exceeded MEM_TIMEOUT.
- halted  output  1  pipeline halted.

Behaviour:
- States: RUN, MEM_WAIT, HALT. Reset: state=RUN, stall_cnt=0, flush_cnt=0, wait counter=0, err_timeout=0, halted=0.
- While rst_n=0, all enables=0 and all flush/bubble outputs=1.
- Controls are combinational from state and inputs. Counters and state are registered.
- Priority, highest first: HALT > memory wait > branch flush > load-use > normal.
- RUN normal: all enables=1, all flush/bubble outputs=0.
- Memory wait: in RUN with mem_req=1 and mem_ready=0:
  - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1; branch and load-use are ignored.
  - Next state is MEM_WAIT; wait counter=1; stall_cnt increments.
- MEM_WAIT:
  - Outputs are the same as the memory-wait case; stall_cnt increments every cycle.
  - When mem_ready=1, outputs revert to RUN priority evaluation in that same cycle (MEM/WB captures the data) and next state is RUN.
  - When the wait counter reaches MEM_TIMEOUT, err_timeout is set (sticky until reset). The state remains MEM_WAIT and the wait counter saturates.
- Branch flush: ex_branch_taken=1 gives ifid_flush=1 and idex_flush=1, with all enables=1 (the PC loads the target). flush_cnt increments. A load-use condition in the same cycle is ignored.
- Load-use hazard:
  - Condition: ex_is_load=1 and ((id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd)), excluding ex_rd=0 when R0_HARDWIRED=1.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, others=1. stall_cnt increments.
  - Exactly one stall cycle per hazard. The following cycle sees the bubble in EX, so the condition clears naturally.
- HALT: wb_halt=1 in any state except during an unfinished memory wait. Next state is HALT and halted=1.
  - In HALT, all enables=0 and all flush/bubble outputs=0; the state is held until reset.
  - Counters freeze in HALT.
- Counters wrap modulo 2^32 without flagging.
- Reset asserted mid-stall or mid-wait: immediate return to reset values, with no partial counter update.

Test Plan:
- Reset release, then 5 idle cycles with all inputs 0 -> all enables=1, flushes=0, stall_cnt=0, flush_cnt=0.
- ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- ex_branch_taken=1 together with the load-use condition above -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> exmem_en=0 and memwb_bubble=1 for 3 cycles; stall_cnt=3; RUN resumes on the ready cycle.
- With MEM_TIMEOUT=4, hold mem_ready=0 for 6 cycles -> err_timeout rises after the 4th wait cycle and stays 1 after mem_ready returns.
- wb_halt=1 for one cycle -> halted=1 permanently with all enables 0. Assert rst_n=0 mid-HALT -> halted=0 and counters=0 immediately (asynchronous).
